cp0_regfile: RTL

//  CP0 register file; consumer of the exception unit's outputs. Latches EPC, Cause, Status.EXL and BadVAddr

---
 rtl/cp0_regfile.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile
// MIPS CP0 register subset: BadVAddr(8), Count(9), Compare(11), Status(12),
// Cause(13), EPC(14) and read-only PRId(15). Latches exception state reported
// by the M-stage exception unit, serves mfc0/mtc0, and runs the Count/Compare
// timer.
// Optional feature macro: CP0_TIMER_INT_EN enables the Count==Compare timer
// interrupt (timer_int_o, Cause.TI, and its OR into Cause.IP7). Without it
// Count/Compare are plain read/write registers and timer_int_o is tied 0.
// -----------------------------------------------------------------------------
module cp0_regfile #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    // Exception-unit type codes
    localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
    localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
    localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

    // CP0 register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03; // IM[15:8], EXL, IE
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300; // software IP[1:0]

    localparam int unsigned     DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [31:0]      status_q,   status_d;
    logic [31:0]      cause_q,    cause_d;
    logic [31:0]      epc_q,      epc_d;
    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [31:0]      count_q,    count_d;
    logic [31:0]      compare_q,  compare_d;
    logic             timer_q,    timer_d;
    logic [DIV_W-1:0] div_q,      div_d;

    logic is_eret;
    logic is_exc;
    logic mtc0_en;
    logic ip7;
    logic ti;

    assign is_eret = (except_type_i == EXC_TYPE_ERET);
    assign is_exc  = (except_type_i != EXC_TYPE_NOEXC) && !is_eret;
    // A flushed instruction's mtc0 must not retire.
    assign mtc0_en = we_i && !is_exc && !is_eret;

    // Next-state for every CP0 register; later assignments take priority.
    always_comb begin
        // NOTE: every variable gets a default first so no latch can be inferred.
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        div_d      = div_q;

        // Count prescaler; an mtc0 Count overrides the hardware tick.
        if (div_q == DIV_LAST) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
        end else begin
            div_d = div_q + 1'b1;
        end
        if (mtc0_en && waddr_i == REG_COUNT) begin
            count_d = data_i;
            div_d   = '0;
        end

`ifdef CP0_TIMER_INT_EN
        timer_d = timer_q;
        if (compare_q != 32'd0 && count_q == compare_q)
            timer_d = 1'b1;
        if (mtc0_en && waddr_i == REG_COMPARE)
            timer_d = 1'b0;
        ip7 = int_i[5] | timer_q;
        ti  = timer_q;
`else
        timer_d = 1'b0;
        ip7     = int_i[5];
        ti      = 1'b0;
`endif

        // Hardware interrupt lines are sampled every cycle.
        cause_d[15:10] = {ip7, int_i[4:0]};
        cause_d[30]    = ti;

        if (mtc0_en) begin
            unique case (waddr_i)
                REG_COMPARE: compare_d = data_i;
                REG_STATUS:  status_d  = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                REG_CAUSE:   cause_d   = (cause_d  & ~CAUSE_WMASK)  | (data_i & CAUSE_WMASK);
                REG_EPC:     epc_d     = data_i;
                default: ;
            endcase
        end

        if (is_exc) begin
            // Nested exceptions keep the original return address.
            if (!status_q[1]) begin
                epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                : current_inst_addr_i;
                cause_d[31] = is_in_delayslot_i;
            end
            status_d[1] = 1'b1;
            unique case (except_type_i)
                EXC_TYPE_INT:  cause_d[6:2] = 5'h00;
                EXC_TYPE_ADEL: begin cause_d[6:2] = 5'h04; badvaddr_d = bad_addr_i; end
                EXC_TYPE_ADES: begin cause_d[6:2] = 5'h05; badvaddr_d = bad_addr_i; end
                EXC_TYPE_SYS:  cause_d[6:2] = 5'h08;
                EXC_TYPE_BP:   cause_d[6:2] = 5'h09;
                EXC_TYPE_RI:   cause_d[6:2] = 5'h0a;
                EXC_TYPE_OV:   cause_d[6:2] = 5'h0c;
                default: ;
            endcase
        end

        if (is_eret)
            status_d[1] = 1'b0;
    end

    // CP0 state registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            timer_q    <= 1'b0;
            div_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            timer_q    <= timer_d;
            div_q      <= div_d;
        end
    end

    // mfc0 read mux; no bypass of a same-cycle mtc0.
    always_comb begin
        data_o = 32'd0;
        unique case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_q;
            REG_COUNT:    data_o = count_q;
            REG_COMPARE:  data_o = compare_q;
            REG_STATUS:   data_o = status_q;
            REG_CAUSE:    data_o = cause_q;
            REG_EPC:      data_o = epc_q;
            REG_PRID:     data_o = PRID_VALUE;
            default:      data_o = 32'd0;
        endcase
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = timer_q;

endmodule
